mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 261 ++++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 584 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`timescale 1ns/1ps
// mem_stage: memory-access pipeline stage between EX and WB.
//
// Holds one instruction from EX, waits for the dcache load response when the
// held instruction is a load that actually issued a request, formats the load
// result (byte/halfword extraction with sign/zero extension) and hands the
// instruction to WB through a register.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   flush               kills the held instruction and the WB capture
//   valid_i .. addr_i   instruction from EX (valid, pc, inst, op, address)
//   is_exception_i      EX exception bits (any set = excepting instruction)
//   reg_write_*_i       EX GPR writeback request
//   csr_*_i             EX CSR write request
//   req_fire_i          EX issued a dcache request this cycle
//   rdata_valid_i/rdata_i  dcache load response (single-cycle pulse)
//   pause_mem_o         combinational stall back to EX
//   wb_*_o              registered instruction / writes presented to WB
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        valid_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] inst_i,
   input  logic [7:0]  aluop_i,
   input  logic [31:0] addr_i,
   input  logic [4:0]  is_exception_i,
   input  logic        reg_write_en_i,
   input  logic [4:0]  reg_write_addr_i,
   input  logic [31:0] reg_write_data_i,
   input  logic        csr_write_en_i,
   input  logic [13:0] csr_addr_i,
   input  logic [31:0] csr_write_data_i,
   input  logic        req_fire_i,
   input  logic        rdata_valid_i,
   input  logic [31:0] rdata_i,
   output logic        pause_mem_o,
   output logic        wb_valid_o,
   output logic [31:0] wb_pc_o,
   output logic [31:0] wb_inst_o,
   output logic [4:0]  wb_is_exception_o,
   output logic        wb_reg_write_en_o,
   output logic [4:0]  wb_reg_write_addr_o,
   output logic [31:0] wb_reg_write_data_o,
   output logic        wb_csr_write_en_o,
   output logic [13:0] wb_csr_addr_o,
   output logic [31:0] wb_csr_write_data_o
);

   // Load opcode encodings; these must match the decoder's aluop values.
   localparam logic [7:0] ALU_LDB  = 8'h20;
   localparam logic [7:0] ALU_LDBU = 8'h21;
   localparam logic [7:0] ALU_LDH  = 8'h22;
   localparam logic [7:0] ALU_LDHU = 8'h23;
   localparam logic [7:0] ALU_LDW  = 8'h24;
   localparam logic [7:0] ALU_LLW  = 8'h25;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t state_reg, state_next;

   // Stage register
   logic        stage_valid_reg;
   logic [31:0] stage_pc_reg;
   logic [31:0] stage_inst_reg;
   logic [7:0]  stage_aluop_reg;
   logic [1:0]  stage_addr_reg;
   logic [4:0]  stage_exc_reg;
   logic        stage_rwe_reg;
   logic [4:0]  stage_rwa_reg;
   logic [31:0] stage_rwd_reg;
   logic        stage_cwe_reg;
   logic [13:0] stage_ca_reg;
   logic [31:0] stage_cwd_reg;
   logic        stage_fire_reg;

   logic        is_load_op;
   logic        stage_is_load;
   logic        no_exception;
   logic [7:0]  rdata_byte [4];
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_data;
   logic [31:0] wb_data_next;

   // Only the low address bits select the byte lane; the rest matter to the
   // dcache alone.
   logic unused_addr;
   assign unused_addr = ^addr_i[31:2];

   // ------------------------------------------------------------------
   // Stage register: advances whenever the stage is not stalled. A flush
   // always clears the valid bit, even while stalled.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stage_valid_reg <= 1'b0;
         stage_pc_reg    <= 32'd0;
         stage_inst_reg  <= 32'd0;
         stage_aluop_reg <= 8'd0;
         stage_addr_reg  <= 2'd0;
         stage_exc_reg   <= 5'd0;
         stage_rwe_reg   <= 1'b0;
         stage_rwa_reg   <= 5'd0;
         stage_rwd_reg   <= 32'd0;
         stage_cwe_reg   <= 1'b0;
         stage_ca_reg    <= 14'd0;
         stage_cwd_reg   <= 32'd0;
         stage_fire_reg  <= 1'b0;
      end else begin
         if (!pause_mem_o) begin
            stage_valid_reg <= valid_i;
            stage_pc_reg    <= pc_i;
            stage_inst_reg  <= inst_i;
            stage_aluop_reg <= aluop_i;
            stage_addr_reg  <= addr_i[1:0];
            stage_exc_reg   <= is_exception_i;
            stage_rwe_reg   <= reg_write_en_i;
            stage_rwa_reg   <= reg_write_addr_i;
            stage_rwd_reg   <= reg_write_data_i;
            stage_cwe_reg   <= csr_write_en_i;
            stage_ca_reg    <= csr_addr_i;
            stage_cwd_reg   <= csr_write_data_i;
            stage_fire_reg  <= req_fire_i;
         end
         if (flush) begin
            stage_valid_reg <= 1'b0;
         end
      end
   end

   always_comb begin
      is_load_op = 1'b0;
      case (stage_aluop_reg)
         ALU_LDB, ALU_LDBU, ALU_LDH, ALU_LDHU, ALU_LDW, ALU_LLW: is_load_op = 1'b1;
         default: is_load_op = 1'b0;
      endcase
   end

   assign no_exception  = (stage_exc_reg == 5'd0);
   // A load that raised an exception or never reached the dcache has no
   // response coming, so it is treated like any single-cycle instruction.
   assign stage_is_load = stage_valid_reg && is_load_op && no_exception && stage_fire_reg;

   // ------------------------------------------------------------------
   // Response-tracking FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      pause_mem_o = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (stage_is_load && !rdata_valid_i) begin
               // A flush in the issue cycle still leaves a response in
               // flight, so it has to be drained.
               state_next = flush ? S_DRAIN : S_WAIT;
            end
            pause_mem_o = stage_is_load && !rdata_valid_i;
         end
         S_WAIT: begin
            if (rdata_valid_i) begin
               state_next = S_IDLE;
            end else if (flush) begin
               state_next = S_DRAIN;
            end
            pause_mem_o = stage_is_load && !rdata_valid_i;
         end
         S_DRAIN: begin
            // Stall EX until the orphaned response has been swallowed so it
            // cannot be mistaken for the reply to a newer load.
            if (rdata_valid_i) begin
               state_next = S_IDLE;
            end
            pause_mem_o = 1'b1;
         end
         default: begin
            state_next  = S_IDLE;
            pause_mem_o = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Load result formatting
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign rdata_byte[gi] = rdata_i[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      load_byte = rdata_byte[stage_addr_reg];
      load_half = stage_addr_reg[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (stage_aluop_reg)
         ALU_LDB:  load_data = {{24{load_byte[7]}}, load_byte};
         ALU_LDBU: load_data = {24'd0, load_byte};
         ALU_LDH:  load_data = {{16{load_half[15]}}, load_half};
         ALU_LDHU: load_data = {16'd0, load_half};
         default:  load_data = rdata_i;
      endcase
      wb_data_next = stage_is_load ? load_data : stage_rwd_reg;
   end

   // ------------------------------------------------------------------
   // WB register. Stall, flush and empty-stage cycles all present a fully
   // zeroed bubble so nothing reaches WB twice or from a dead slot.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_valid_o          <= 1'b0;
         wb_pc_o             <= 32'd0;
         wb_inst_o           <= 32'd0;
         wb_is_exception_o   <= 5'd0;
         wb_reg_write_en_o   <= 1'b0;
         wb_reg_write_addr_o <= 5'd0;
         wb_reg_write_data_o <= 32'd0;
         wb_csr_write_en_o   <= 1'b0;
         wb_csr_addr_o       <= 14'd0;
         wb_csr_write_data_o <= 32'd0;
      end else if (flush || pause_mem_o || !stage_valid_reg) begin
         wb_valid_o          <= 1'b0;
         wb_pc_o             <= 32'd0;
         wb_inst_o           <= 32'd0;
         wb_is_exception_o   <= 5'd0;
         wb_reg_write_en_o   <= 1'b0;
         wb_reg_write_addr_o <= 5'd0;
         wb_reg_write_data_o <= 32'd0;
         wb_csr_write_en_o   <= 1'b0;
         wb_csr_addr_o       <= 14'd0;
         wb_csr_write_data_o <= 32'd0;
      end else begin
         wb_valid_o          <= 1'b1;
         wb_pc_o             <= stage_pc_reg;
         wb_inst_o           <= stage_inst_reg;
         wb_is_exception_o   <= stage_exc_reg;
         wb_reg_write_en_o   <= stage_rwe_reg && no_exception;
         wb_reg_write_addr_o <= stage_rwa_reg;
         wb_reg_write_data_o <= wb_data_next;
         wb_csr_write_en_o   <= stage_cwe_reg && no_exception;
         wb_csr_addr_o       <= stage_ca_reg;
         wb_csr_write_data_o <= stage_cwd_reg;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
// Testbench for mem_stage: directed scenarios plus a randomized in-order
// scoreboard run against a behavioural model of the stage.
module tb_mem_stage;

   localparam logic [7:0] ALU_ADD  = 8'h01;
   localparam logic [7:0] ALU_SW   = 8'h30;
   localparam logic [7:0] ALU_CSR  = 8'h40;
   localparam logic [7:0] ALU_LDB  = 8'h20;
   localparam logic [7:0] ALU_LDBU = 8'h21;
   localparam logic [7:0] ALU_LDH  = 8'h22;
   localparam logic [7:0] ALU_LDHU = 8'h23;
   localparam logic [7:0] ALU_LDW  = 8'h24;
   localparam logic [7:0] ALU_LLW  = 8'h25;
   localparam int NUM_RAND = 300;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [7:0]  aluop;
      logic [31:0] addr;
      logic [4:0]  exc;
      logic        rwe;
      logic [4:0]  rwa;
      logic [31:0] rwd;
      logic        cwe;
      logic [13:0] ca;
      logic [31:0] cwd;
      logic        fire;
      logic [31:0] rdata;
      logic [1:0]  delay;
   } ex_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [4:0]  exc;
      logic        rwe;
      logic [4:0]  rwa;
      logic [31:0] rwd;
      logic        cwe;
      logic [13:0] ca;
      logic [31:0] cwd;
   } wb_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        valid_i;
   logic [31:0] pc_i, inst_i, addr_i, reg_write_data_i, csr_write_data_i, rdata_i;
   logic [7:0]  aluop_i;
   logic [4:0]  is_exception_i, reg_write_addr_i;
   logic        reg_write_en_i, csr_write_en_i, req_fire_i, rdata_valid_i;
   logic [13:0] csr_addr_i;
   logic        pause_mem_o, wb_valid_o, wb_reg_write_en_o, wb_csr_write_en_o;
   logic [31:0] wb_pc_o, wb_inst_o, wb_reg_write_data_o, wb_csr_write_data_o;
   logic [4:0]  wb_is_exception_o, wb_reg_write_addr_o;
   logic [13:0] wb_csr_addr_o;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk                 (clk),
      .rst                 (rst),
      .flush               (flush),
      .valid_i             (valid_i),
      .pc_i                (pc_i),
      .inst_i              (inst_i),
      .aluop_i             (aluop_i),
      .addr_i              (addr_i),
      .is_exception_i      (is_exception_i),
      .reg_write_en_i      (reg_write_en_i),
      .reg_write_addr_i    (reg_write_addr_i),
      .reg_write_data_i    (reg_write_data_i),
      .csr_write_en_i      (csr_write_en_i),
      .csr_addr_i          (csr_addr_i),
      .csr_write_data_i    (csr_write_data_i),
      .req_fire_i          (req_fire_i),
      .rdata_valid_i       (rdata_valid_i),
      .rdata_i             (rdata_i),
      .pause_mem_o         (pause_mem_o),
      .wb_valid_o          (wb_valid_o),
      .wb_pc_o             (wb_pc_o),
      .wb_inst_o           (wb_inst_o),
      .wb_is_exception_o   (wb_is_exception_o),
      .wb_reg_write_en_o   (wb_reg_write_en_o),
      .wb_reg_write_addr_o (wb_reg_write_addr_o),
      .wb_reg_write_data_o (wb_reg_write_data_o),
      .wb_csr_write_en_o   (wb_csr_write_en_o),
      .wb_csr_addr_o       (wb_csr_addr_o),
      .wb_csr_write_data_o (wb_csr_write_data_o)
   );

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ex(input ex_t e);
      valid_i          = e.valid;
      pc_i             = e.pc;
      inst_i           = e.inst;
      aluop_i          = e.aluop;
      addr_i           = e.addr;
      is_exception_i   = e.exc;
      reg_write_en_i   = e.rwe;
      reg_write_addr_i = e.rwa;
      reg_write_data_i = e.rwd;
      csr_write_en_i   = e.cwe;
      csr_addr_i       = e.ca;
      csr_write_data_i = e.cwd;
      req_fire_i       = e.fire;
   endtask

   // Empty EX slot with garbage on the payload fields.
   task automatic idle_ex();
      valid_i          = 1'b0;
      pc_i             = $urandom;
      inst_i           = $urandom;
      aluop_i          = ALU_ADD;
      addr_i           = $urandom;
      is_exception_i   = 5'd0;
      reg_write_en_i   = 1'b1;
      reg_write_addr_i = 5'($urandom);
      reg_write_data_i = $urandom;
      csr_write_en_i   = 1'b1;
      csr_addr_i       = 14'($urandom);
      csr_write_data_i = $urandom;
      req_fire_i       = 1'b0;
   endtask

   function automatic ex_t mk_instr(input logic [7:0] op, input logic [31:0] addr, input logic fire);
      ex_t e;
      e.valid = 1'b1;
      e.pc    = $urandom & 32'hFFFF_FFFC;
      e.inst  = $urandom;
      e.aluop = op;
      e.addr  = addr;
      e.exc   = 5'd0;
      e.rwe   = 1'b1;
      e.rwa   = 5'($urandom_range(31, 1));
      e.rwd   = $urandom;
      e.cwe   = 1'b0;
      e.ca    = 14'($urandom);
      e.cwd   = $urandom;
      e.fire  = fire;
      e.rdata = 32'd0;
      e.delay = 2'd0;
      return e;
   endfunction

   function automatic logic [7:0] pick_load(input int i);
      case (i)
         0: return ALU_LDB;
         1: return ALU_LDBU;
         2: return ALU_LDH;
         3: return ALU_LDHU;
         4: return ALU_LDW;
         default: return ALU_LLW;
      endcase
   endfunction

   function automatic ex_t rand_instr();
      ex_t e;
      int kind;
      e = mk_instr(ALU_ADD, $urandom, 1'b0);
      e.valid = ($urandom_range(5, 0) != 0);
      e.rdata = $urandom;
      e.delay = 2'($urandom_range(3, 0));
      if ($urandom_range(5, 0) == 0) e.exc = 5'($urandom_range(31, 1));
      kind = $urandom_range(3, 0);
      case (kind)
         0: e.aluop = ALU_ADD;
         1: begin e.aluop = ALU_SW; e.rwe = 1'b0; e.fire = 1'b1; end
         2: begin e.aluop = ALU_CSR; e.cwe = 1'b1; end
         default: begin
            e.aluop = pick_load($urandom_range(5, 0));
            e.fire  = ($urandom_range(7, 0) != 0);
         end
      endcase
      return e;
   endfunction

   // ---------------- reference model ----------------
   function automatic bit model_is_load(input ex_t e);
      bit op_ok;
      op_ok = (e.aluop == ALU_LDB) || (e.aluop == ALU_LDBU) || (e.aluop == ALU_LDH) ||
              (e.aluop == ALU_LDHU) || (e.aluop == ALU_LDW) || (e.aluop == ALU_LLW);
      return e.valid && op_ok && (e.exc == 5'd0) && e.fire;
   endfunction

   function automatic logic [31:0] load_result(input logic [7:0] op, input logic [31:0] addr,
                                               input logic [31:0] d);
      int unsigned b, h;
      b = (d >> (int'(addr[1:0]) * 8)) & 32'hFF;
      h = (d >> (int'(addr[1]) * 16)) & 32'hFFFF;
      case (op)
         ALU_LDB:  return (b >= 128) ? (b + 32'hFFFF_FF00) : b;
         ALU_LDBU: return b;
         ALU_LDH:  return (h >= 32768) ? (h + 32'hFFFF_0000) : h;
         ALU_LDHU: return h;
         default:  return d;
      endcase
   endfunction

   function automatic wb_t expected_wb(input ex_t e);
      wb_t w;
      w.valid = 1'b1;
      w.pc    = e.pc;
      w.inst  = e.inst;
      w.exc   = e.exc;
      w.rwe   = e.rwe && (e.exc == 5'd0);
      w.rwa   = e.rwa;
      w.rwd   = model_is_load(e) ? load_result(e.aluop, e.addr, e.rdata) : e.rwd;
      w.cwe   = e.cwe && (e.exc == 5'd0);
      w.ca    = e.ca;
      w.cwd   = e.cwd;
      return w;
   endfunction

   function automatic wb_t dut_wb();
      wb_t w;
      w.valid = wb_valid_o;
      w.pc    = wb_pc_o;
      w.inst  = wb_inst_o;
      w.exc   = wb_is_exception_o;
      w.rwe   = wb_reg_write_en_o;
      w.rwa   = wb_reg_write_addr_o;
      w.rwd   = wb_reg_write_data_o;
      w.cwe   = wb_csr_write_en_o;
      w.ca    = wb_csr_addr_o;
      w.cwd   = wb_csr_write_data_o;
      return w;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      ex_t e;
      rst = 1'b0;
      e = mk_instr(ALU_LDW, 32'h0, 1'b1);
      drive_ex(e);
      rdata_valid_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      tests_run++;
      if (pause_mem_o !== 1'b0) begin tests_failed++; $display("FAIL reset_pause: got %b expected 0", pause_mem_o); end
      tests_run++;
      if (wb_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid_o); end
      tests_run++;
      if (wb_pc_o !== 32'd0 || wb_reg_write_data_o !== 32'd0 || wb_is_exception_o !== 5'd0) begin
         tests_failed++;
         $display("FAIL reset_wb_fields: got pc=%h data=%h exc=%b expected zeros", wb_pc_o, wb_reg_write_data_o, wb_is_exception_o);
      end
      tests_run++;
      if (wb_reg_write_en_o !== 1'b0 || wb_csr_write_en_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_wb_en: got rwe=%b cwe=%b expected 0 0", wb_reg_write_en_o, wb_csr_write_en_o);
      end
      cyc();
      rst = 1'b1;
      idle_ex();
      @(negedge clk);
      tests_run++;
      if (wb_valid_o !== 1'b0 || pause_mem_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_release: got valid=%b pause=%b expected 0 0", wb_valid_o, pause_mem_o);
      end
      cyc();
   endtask

   task automatic test_ldb_wait();
      ex_t e;
      int wb_seen;
      e = mk_instr(ALU_LDB, 32'h0000_1003, 1'b1);
      drive_ex(e);
      rdata_valid_i = 1'b0;
      cyc();
      idle_ex();
      wb_seen = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         tests_run++;
         if (pause_mem_o !== 1'b1) begin tests_failed++; $display("FAIL ldb_pause_wait%0d: got %b expected 1", k, pause_mem_o); end
         if (wb_valid_o === 1'b1) wb_seen++;
         cyc();
      end
      rdata_valid_i = 1'b1;
      rdata_i       = 32'h80FF_1234;
      @(negedge clk);
      tests_run++;
      if (pause_mem_o !== 1'b0) begin tests_failed++; $display("FAIL ldb_pause_resp: got %b expected 0", pause_mem_o); end
      if (wb_valid_o === 1'b1) wb_seen++;
      cyc();
      rdata_valid_i = 1'b0;
      rdata_i       = $urandom;
      @(negedge clk);
      tests_run++;
      if (wb_valid_o !== 1'b1 || wb_reg_write_data_o !== 32'hFFFF_FF80 || wb_pc_o !== e.pc) begin
         tests_failed++;
         $display("FAIL ldb_wb: got valid=%b data=%h pc=%h expected 1 ffffff80 %h", wb_valid_o, wb_reg_write_data_o, wb_pc_o, e.pc);
      end
      cyc();
      @(negedge clk);
      if (wb_valid_o === 1'b1) wb_seen++;
      tests_run++;
      if (wb_seen !== 0) begin tests_failed++; $display("FAIL ldb_wb_once: got %0d extra wb_valid cycles expected 0", wb_seen); end
      cyc();
   endtask

   task automatic test_ldhu_same();
      ex_t e;
      e = mk_instr(ALU_LDHU, 32'h0000_2002, 1'b1);
      drive_ex(e);
      cyc();
      idle_ex();
      rdata_valid_i = 1'b1;
      rdata_i       = 32'hBEEF_0001;
      @(negedge clk);
      tests_run++;
      if (pause_mem_o !== 1'b0) begin tests_failed++; $display("FAIL ldhu_pause: got %b expected 0", pause_mem_o); end
      cyc();
      rdata_valid_i = 1'b0;
      @(negedge clk);
      tests_run++;
      if (wb_valid_o !== 1'b1 || wb_reg_write_data_o !== 32'h0000_BEEF) begin
         tests_failed++;
         $display("FAIL ldhu_wb: got valid=%b data=%h expected 1 0000beef", wb_valid_o, wb_reg_write_data_o);
      end
      cyc();
   endtask

   task automatic test_flush_wait();
      ex_t e;
      logic [4:0] pause_exp;
      logic [4:0] pause_got;
      logic [4:0] wbv_got;
      e = mk_instr(ALU_LDW, 32'h0000_4000, 1'b1);
      drive_ex(e);
      cyc();
      idle_ex();
      rdata_valid_i = 1'b0;
      // cycle 0 enters WAIT, cycle 1 flush, cycles 2-3 DRAIN (response in 3), cycle 4 free
      pause_exp = 5'b01111;
      for (int k = 0; k < 5; k++) begin
         flush         = (k == 1);
         rdata_valid_i = (k == 3);
         rdata_i       = $urandom;
         @(negedge clk);
         pause_got[k] = pause_mem_o;
         wbv_got[k]   = wb_valid_o;
         cyc();
      end
      flush         = 1'b0;
      rdata_valid_i = 1'b0;
      tests_run++;
      if (pause_got !== pause_exp) begin tests_failed++; $display("FAIL flush_drain_pause: got %b expected %b", pause_got, pause_exp); end
      tests_run++;
      if (wbv_got !== 5'b00000) begin tests_failed++; $display("FAIL flush_drain_wb: got %b expected 00000", wbv_got); end
   endtask

   task automatic test_exception();
      ex_t e;
      e = mk_instr(ALU_SW, $urandom, 1'b1);
      e.exc = 5'b00001;
      e.cwe = 1'b1;
      drive_ex(e);
      cyc();
      idle_ex();
      @(negedge clk);
      tests_run++;
      if (pause_mem_o !== 1'b0) begin tests_failed++; $display("FAIL exc_pause: got %b expected 0", pause_mem_o); end
      cyc();
      @(negedge clk);
      tests_run++;
      if (wb_valid_o !== 1'b1 || wb_reg_write_en_o !== 1'b0 || wb_csr_write_en_o !== 1'b0 ||
          wb_is_exception_o !== 5'b00001 || wb_pc_o !== e.pc) begin
         tests_failed++;
         $display("FAIL exc_wb: got valid=%b rwe=%b cwe=%b exc=%b pc=%h expected 1 0 0 00001 %h",
                  wb_valid_o, wb_reg_write_en_o, wb_csr_write_en_o, wb_is_exception_o, wb_pc_o, e.pc);
      end
      cyc();
   endtask

   task automatic test_back_to_back();
      ex_t a1, ld, a2;
      a1 = mk_instr(ALU_ADD, $urandom, 1'b0);
      ld = mk_instr(ALU_LDW, 32'h0000_3000, 1'b1);
      a2 = mk_instr(ALU_ADD, $urandom, 1'b0);
      drive_ex(a1);
      cyc();
      drive_ex(ld);
      cyc();
      drive_ex(a2);
      rdata_valid_i = 1'b0;
      @(negedge clk);
      tests_run++;
      if (pause_mem_o !== 1'b1 || wb_valid_o !== 1'b1 || wb_pc_o !== a1.pc || wb_reg_write_data_o !== a1.rwd) begin
         tests_failed++;
         $display("FAIL b2b_add1: got pause=%b valid=%b pc=%h data=%h expected 1 1 %h %h",
                  pause_mem_o, wb_valid_o, wb_pc_o, wb_reg_write_data_o, a1.pc, a1.rwd);
      end
      cyc();
      rdata_valid_i = 1'b1;
      rdata_i       = 32'h1234_5678;
      @(negedge clk);
      tests_run++;
      if (pause_mem_o !== 1'b0 || wb_valid_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_bubble: got pause=%b valid=%b expected 0 0", pause_mem_o, wb_valid_o);
      end
      cyc();
      idle_ex();
      rdata_valid_i = 1'b0;
      @(negedge clk);
      tests_run++;
      if (wb_valid_o !== 1'b1 || wb_pc_o !== ld.pc || wb_reg_write_data_o !== 32'h1234_5678) begin
         tests_failed++;
         $display("FAIL b2b_ldw: got valid=%b pc=%h data=%h expected 1 %h 12345678", wb_valid_o, wb_pc_o, wb_reg_write_data_o, ld.pc);
      end
      cyc();
      @(negedge clk);
      tests_run++;
      if (wb_valid_o !== 1'b1 || wb_pc_o !== a2.pc || wb_reg_write_data_o !== a2.rwd) begin
         tests_failed++;
         $display("FAIL b2b_add2: got valid=%b pc=%h data=%h expected 1 %h %h", wb_valid_o, wb_pc_o, wb_reg_write_data_o, a2.pc, a2.rwd);
      end
      cyc();
   endtask

   task automatic test_reset_in_wait();
      ex_t ld, a;
      ld = mk_instr(ALU_LDW, 32'h0000_5000, 1'b1);
      drive_ex(ld);
      cyc();
      idle_ex();
      rdata_valid_i = 1'b0;
      cyc();
      @(negedge clk);
      tests_run++;
      if (pause_mem_o !== 1'b1) begin tests_failed++; $display("FAIL rstwait_pre_pause: got %b expected 1", pause_mem_o); end
      #2;
      rst = 1'b0;
      #1;
      tests_run++;
      if (pause_mem_o !== 1'b0 || wb_valid_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstwait_async: got pause=%b valid=%b expected 0 0", pause_mem_o, wb_valid_o);
      end
      cyc();
      rst = 1'b1;
      cyc();
      rdata_valid_i = 1'b1;
      rdata_i       = $urandom;
      @(negedge clk);
      tests_run++;
      if (pause_mem_o !== 1'b0) begin tests_failed++; $display("FAIL rstwait_stray_pause: got %b expected 0", pause_mem_o); end
      cyc();
      rdata_valid_i = 1'b0;
      a = mk_instr(ALU_ADD, $urandom, 1'b0);
      drive_ex(a);
      @(negedge clk);
      tests_run++;
      if (dut_wb() !== '0 || pause_mem_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstwait_wb_zero: got wb=%h pause=%b expected all zero", dut_wb(), pause_mem_o);
      end
      cyc();
      idle_ex();
      @(negedge clk);
      tests_run++;
      if (wb_valid_o !== 1'b0) begin tests_failed++; $display("FAIL rstwait_add_early: got valid=%b expected 0", wb_valid_o); end
      cyc();
      @(negedge clk);
      tests_run++;
      if (wb_valid_o !== 1'b1 || wb_pc_o !== a.pc) begin
         tests_failed++;
         $display("FAIL rstwait_add_after: got valid=%b pc=%h expected 1 %h", wb_valid_o, wb_pc_o, a.pc);
      end
      cyc();
   endtask

   // Randomized in-order stream. The model keeps the instruction occupying
   // the stage and how many response-less cycles remain for it; expected WB
   // records are queued in acceptance order.
   task automatic test_random();
      ex_t cur, stg, empty;
      wb_t q[$];
      wb_t exp_w, act_w;
      logic stg_load, exp_pause;
      int r, issued, cycles, wb_count, push_count;
      stg_load = 1'b0;
      r = 0; issued = 0; cycles = 0; wb_count = 0; push_count = 0;
      empty = '0;
      cur = rand_instr();
      while ((issued < NUM_RAND || stg_load || q.size() != 0) && cycles < 4000) begin
         if (issued < NUM_RAND) drive_ex(cur); else idle_ex();
         if (stg_load && r == 0) begin
            rdata_valid_i = 1'b1;
            rdata_i       = stg.rdata;
         end else begin
            rdata_valid_i = !stg_load && ($urandom_range(3, 0) == 0);
            rdata_i       = $urandom;
         end
         exp_pause = stg_load && (r != 0);
         @(negedge clk);
         tests_run++;
         if (pause_mem_o !== exp_pause) begin
            tests_failed++;
            $display("FAIL rand_pause cycle %0d: got %b expected %b", cycles, pause_mem_o, exp_pause);
         end
         if (wb_valid_o === 1'b1) begin
            wb_count++;
            act_w = dut_wb();
            tests_run++;
            if (q.size() == 0) begin
               tests_failed++;
               $display("FAIL rand_wb_extra cycle %0d: got wb=%h expected no writeback", cycles, act_w);
            end else begin
               exp_w = q.pop_front();
               if (act_w !== exp_w) begin
                  tests_failed++;
                  $display("FAIL rand_wb cycle %0d: got %h expected %h", cycles, act_w, exp_w);
               end
            end
         end
         cyc();
         cycles++;
         if (!exp_pause) begin
            stg      = (issued < NUM_RAND) ? cur : empty;
            stg_load = model_is_load(stg);
            r        = int'(stg.delay);
            if (stg.valid) begin
               q.push_back(expected_wb(stg));
               push_count++;
            end
            if (issued < NUM_RAND) begin
               issued++;
               cur = rand_instr();
            end
         end else begin
            r--;
         end
      end
      rdata_valid_i = 1'b0;
      tests_run++;
      if (q.size() != 0 || wb_count != push_count) begin
         tests_failed++;
         $display("FAIL rand_drain: got %0d writebacks with %0d pending expected %0d with 0 pending",
                  wb_count, q.size(), push_count);
      end
   endtask

   initial begin
      rst           = 1'b0;
      flush         = 1'b0;
      rdata_valid_i = 1'b0;
      rdata_i       = 32'd0;
      idle_ex();
      test_reset();
      test_ldb_wait();
      test_ldhu_same();
      test_flush_wait();
      test_exception();
      test_back_to_back();
      test_reset_in_wait();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
